// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - issue/writeback controller for the 3-bit-command ALU with a 4x8 register file
module alu_issue #(
    parameter int A = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         instr_valid,
    input  logic [8:0]   instr,
    output logic         instr_ready,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [7:0]   wr_data,
    output logic [A-1:0] alu_cmd,
    output logic [7:0]   inA,
    output logic [7:0]   inB,
    output logic         sc_i,
    input  logic [7:0]   rslt,
    input  logic         sc_o,
    input  logic         pari,
    output logic         done,
    output logic [1:0]   wb_addr,
    output logic [7:0]   wb_data,
    output logic         carry_flag,
    output logic         parity_flag,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [7:0]  regs [4];
    logic [8:0]  instr_q;
    logic [2:0]  cmd_q;
    logic [1:0]  ra_q;
    logic [1:0]  rb_q;
    logic [1:0]  rd_q;
    logic        accept;
    logic        accept_op;

    assign cmd_q = instr_q[8:6];
    assign ra_q  = instr_q[5:4];
    assign rb_q  = instr_q[3:2];
    assign rd_q  = instr_q[1:0];

    // Preload wins over issue, and nothing is accepted while reset is held.
    assign instr_ready = reset_n & (state == S_IDLE) & ~wr_en;
    assign accept      = instr_valid & instr_ready;
    assign accept_op   = accept & (instr[8:6] != 3'b000);

    assign busy = (state != S_IDLE);
    assign sc_i = carry_flag;

    always_comb begin
        state_nx = state;
        alu_cmd  = '0;
        inA      = 8'h00;
        inB      = 8'h00;
        case (state)
            S_IDLE: begin
                if (accept_op) begin
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_cmd  = A'(cmd_q);
                inA      = regs[ra_q];
                inB      = regs[rb_q];
                state_nx = S_WB;
            end
            S_WB: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= 9'h000;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    // wb_data doubles as the captured result register, so the WB write and the
    // reported value can never disagree.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done        <= 1'b0;
            wb_addr     <= 2'd0;
            wb_data     <= 8'h00;
            carry_flag  <= 1'b0;
            parity_flag <= 1'b0;
        end else begin
            done <= (state == S_EXEC);
            if (state == S_EXEC) begin
                wb_addr     <= rd_q;
                wb_data     <= rslt;
                carry_flag  <= sc_o;
                parity_flag <= pari;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (state == S_WB) begin
            regs[rd_q] <= wb_data;
        end else if ((state == S_IDLE) && wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a behavioural ALU
module tb_alu_issue;

    logic       clk;
    logic       reset_n;
    logic       instr_valid;
    logic [8:0] instr;
    logic       instr_ready;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] alu_cmd;
    logic [7:0] inA;
    logic [7:0] inB;
    logic       sc_i;
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       done;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       carry_flag;
    logic       parity_flag;
    logic       busy;

    logic       force_sc;
    logic       force_pari;
    int         passed;
    int         total;

    alu_issue #(.A(3)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_ready(instr_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .alu_cmd(alu_cmd),
        .inA(inA),
        .inB(inB),
        .sc_i(sc_i),
        .rslt(rslt),
        .sc_o(sc_o),
        .pari(pari),
        .done(done),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .carry_flag(carry_flag),
        .parity_flag(parity_flag),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rslt = 8'h00;
        case (alu_cmd)
            3'd1: rslt = inA ^ inB;
            3'd2: rslt = (inA != inB) ? 8'd1 : 8'd0;
            3'd3: rslt = inA + inB;
            3'd4: rslt = inB << inA;
            3'd5: rslt = inB >> inA;
            3'd6: rslt = inB;
            3'd7: rslt = inA;
            default: rslt = 8'h00;
        endcase
        sc_o = force_sc;
        pari = force_pari;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Called at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run(input string tag, input logic [8:0] ins, input logic [7:0] ea,
                       input logic [7:0] eb, input logic [7:0] ewb, input logic esc);
        instr       = ins;
        instr_valid = 1'b1;
        #1;
        check({tag, ".ready"}, instr_ready, 1'b1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check({tag, ".cmd"}, alu_cmd, ins[8:6]);
        check({tag, ".inA"}, inA, ea);
        check({tag, ".inB"}, inB, eb);
        check({tag, ".sc_i"}, sc_i, esc);
        check({tag, ".busy_exec"}, busy, 1'b1);
        check({tag, ".ready_exec"}, instr_ready, 1'b0);
        @(negedge clk);
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".wb_addr"}, wb_addr, ins[1:0]);
        check({tag, ".wb_data"}, wb_data, ewb);
        check({tag, ".ready_wb"}, instr_ready, 1'b0);
        check({tag, ".cmd_wb"}, alu_cmd, 3'd0);
        @(negedge clk);
        check({tag, ".done_clr"}, done, 1'b0);
        check({tag, ".busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 9'h000;
        wr_en       = 1'b0;
        wr_addr     = 2'd0;
        wr_data     = 8'h00;
        force_sc    = 1'b0;
        force_pari  = 1'b0;

        repeat (2) @(negedge clk);
        instr_valid = 1'b1;
        #1;
        check("rst.ready", instr_ready, 1'b0);
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.cmd", alu_cmd, 3'd0);
        check("rst.wb_data", wb_data, 8'h00);
        check("rst.carry", carry_flag, 1'b0);
        instr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("idle.ready", instr_ready, 1'b1);
        @(negedge clk);

        preload(2'd0, 8'd5);
        preload(2'd1, 8'd7);
        run("add", 9'b011_00_01_10, 8'd5, 8'd7, 8'd12, 1'b0);
        run("rd_r2", 9'b111_10_00_11, 8'd12, 8'd5, 8'd12, 1'b0);

        preload(2'd3, 8'hF0);
        run("add_wrap", 9'b011_11_11_11, 8'hF0, 8'hF0, 8'hE0, 1'b0);
        run("pass_a", 9'b111_11_00_00, 8'hE0, 8'd5, 8'hE0, 1'b0);

        preload(2'd0, 8'd2);
        preload(2'd1, 8'h0B);
        run("shl", 9'b100_00_01_11, 8'd2, 8'h0B, 8'h2C, 1'b0);
        run("cne", 9'b010_01_01_00, 8'h0B, 8'h0B, 8'h00, 1'b0);

        wr_en       = 1'b1;
        wr_addr     = 2'd2;
        wr_data     = 8'h33;
        instr_valid = 1'b1;
        instr       = 9'b011_00_01_10;
        #1;
        check("pre_prio.ready", instr_ready, 1'b0);
        @(negedge clk);
        wr_en       = 1'b0;
        instr_valid = 1'b0;
        #1;
        check("pre_prio.busy", busy, 1'b0);
        run("rd_pre", 9'b111_10_00_01, 8'h33, 8'h00, 8'h33, 1'b0);

        instr       = 9'b000_11_11_11;
        instr_valid = 1'b1;
        #1;
        check("nop.ready", instr_ready, 1'b1);
        @(negedge clk);
        check("nop.busy", busy, 1'b0);
        check("nop.done", done, 1'b0);
        check("nop.ready_next", instr_ready, 1'b1);
        run("xor", 9'b001_01_10_11, 8'h33, 8'h33, 8'h00, 1'b0);

        force_sc   = 1'b1;
        force_pari = 1'b1;
        run("pass_b", 9'b110_00_01_10, 8'h00, 8'h33, 8'h33, 1'b0);
        force_sc   = 1'b0;
        force_pari = 1'b0;
        check("flag.carry", carry_flag, 1'b1);
        check("flag.parity", parity_flag, 1'b1);
        run("xor_sci", 9'b001_01_11_00, 8'h33, 8'h00, 8'h33, 1'b1);
        check("flag.carry_clr", carry_flag, 1'b0);

        instr       = 9'b011_00_01_10;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        check("abort.in_exec", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("abort.busy", busy, 1'b0);
        check("abort.cmd", alu_cmd, 3'd0);
        check("abort.done", done, 1'b0);
        check("abort.ready", instr_ready, 1'b0);
        @(negedge clk);
        check("abort.no_done", done, 1'b0);
        reset_n = 1'b1;
        #1;
        check("abort.ready_rel", instr_ready, 1'b1);
        run("rd_r2_rst", 9'b111_10_00_01, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
